// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM burst arbiter.
// Holds the FSM encoding, beat-counter width and address step helper.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DRAIN = 2'd2
  } arb_state_e;

  localparam int CNT_W = 4;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_BYTE_INC = DEF_DATA_WIDTH / 8;

  function automatic int beat_bytes(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/sram_arb_rr.sv
// Two-way requester pick with last-grant memory.
// SRAM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins ties).
module sram_arb_rr
  import sram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic       pick,
  output logic       any_req
);

  logic last_q;

  assign any_req = |req;

`ifdef SRAM_ARB_FIXED_PRIO_EN
  assign pick = req[1] & ~req[0];
`else
  // on a tie, favour whoever did not win last time
  assign pick = req[1] & (~req[0] | ~last_q);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (take) begin
      last_q <= pick;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-port burst arbiter in front of a 1-cycle-latency SRAM.
// Tie policy set by SRAM_ARB_FIXED_PRIO_EN (see sram_arb_rr).
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    p0_req,
  input  logic                    p0_we,
  input  logic [BUS_WIDTH-1:0]    p0_addr,
  input  logic [3:0]              p0_len,
  input  logic                    p0_wvalid,
  input  logic [DATA_WIDTH-1:0]   p0_wdata,
  input  logic [DATA_WIDTH/8-1:0] p0_wstrb,
  output logic                    p0_wready,
  output logic                    p0_rvalid,
  output logic [DATA_WIDTH-1:0]   p0_rdata,
  output logic                    p0_gnt,
  output logic                    p0_done,
  input  logic                    p1_req,
  input  logic                    p1_we,
  input  logic [BUS_WIDTH-1:0]    p1_addr,
  input  logic [3:0]              p1_len,
  input  logic                    p1_wvalid,
  input  logic [DATA_WIDTH-1:0]   p1_wdata,
  input  logic [DATA_WIDTH/8-1:0] p1_wstrb,
  output logic                    p1_wready,
  output logic                    p1_rvalid,
  output logic [DATA_WIDTH-1:0]   p1_rdata,
  output logic                    p1_gnt,
  output logic                    p1_done,
  output logic [BUS_WIDTH-1:0]    ram_raddr,
  output logic                    ram_ren,
  input  logic [DATA_WIDTH-1:0]   ram_rdata,
  output logic [BUS_WIDTH-1:0]    ram_waddr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  output logic [DATA_WIDTH/8-1:0] ram_wen
);

  localparam int SW = DATA_WIDTH / 8;
  localparam logic [BUS_WIDTH-1:0] INC =
    BUS_WIDTH'(beat_bytes(DATA_WIDTH));

  arb_state_e state_q, state_d;

  logic                  owner_q;
  logic                  we_q;
  logic                  rvalid_q;
  logic [CNT_W-1:0]      len_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [BUS_WIDTH-1:0]  addr_q;
  logic                  take;
  logic                  pick;
  logic                  any_req;
  logic                  sel_wvalid;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [SW-1:0]         sel_wstrb;
  logic                  active;
  logic                  rd_beat;
  logic                  wr_beat;
  logic                  beat;
  logic                  last_beat;
  logic                  done;

  sram_arb_rr u_rr (
    .clk     (aclk),
    .rst     (areset),
    .req     ({p1_req, p0_req}),
    .take    (take),
    .pick    (pick),
    .any_req (any_req)
  );

  assign active = (state_q != S_IDLE);
  assign take   = (state_q == S_IDLE) && any_req;

  assign sel_wvalid = owner_q ? p1_wvalid : p0_wvalid;
  assign sel_wdata  = owner_q ? p1_wdata  : p0_wdata;
  assign sel_wstrb  = owner_q ? p1_wstrb  : p0_wstrb;

  assign rd_beat   = (state_q == S_BURST) && !we_q;
  assign wr_beat   = (state_q == S_BURST) && we_q && sel_wvalid;
  assign beat      = rd_beat | wr_beat;
  assign last_beat = beat && (cnt_q == len_q);
  // reads finish in DRAIN alongside the final returned beat
  assign done = (wr_beat && last_beat) || (state_q == S_DRAIN);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (any_req) state_d = S_BURST;
      S_BURST: if (last_beat) state_d = we_q ? S_IDLE : S_DRAIN;
      S_DRAIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      len_q    <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_beat;
      if (take) begin
        owner_q <= pick;
        we_q    <= pick ? p1_we   : p0_we;
        addr_q  <= pick ? p1_addr : p0_addr;
        len_q   <= pick ? p1_len  : p0_len;
        cnt_q   <= '0;
      end else if (beat) begin
        addr_q <= addr_q + INC;
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

  assign p0_gnt    = active && !owner_q;
  assign p1_gnt    = active && owner_q;
  assign p0_wready = wr_beat && !owner_q;
  assign p1_wready = wr_beat && owner_q;
  assign p0_rvalid = rvalid_q && !owner_q;
  assign p1_rvalid = rvalid_q && owner_q;
  assign p0_rdata  = p0_rvalid ? ram_rdata : '0;
  assign p1_rdata  = p1_rvalid ? ram_rdata : '0;
  assign p0_done   = done && !owner_q;
  assign p1_done   = done && owner_q;

  assign ram_ren   = rd_beat;
  assign ram_raddr = rd_beat ? addr_q : '0;
  assign ram_wen   = wr_beat ? sel_wstrb : '0;
  assign ram_waddr = wr_beat ? addr_q : '0;
  assign ram_wdata = wr_beat ? sel_wdata : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: burst table plus
// arbitration and mid-burst reset sequences.
module tb_sram_port_arbiter;

  logic        aclk = 1'b0;
  logic        areset;
  logic        p0_req, p0_we, p0_wvalid;
  logic [31:0] p0_addr;
  logic [3:0]  p0_len;
  logic [63:0] p0_wdata;
  logic [7:0]  p0_wstrb;
  logic        p0_wready, p0_rvalid, p0_gnt, p0_done;
  logic [63:0] p0_rdata;
  logic        p1_req, p1_we, p1_wvalid;
  logic [31:0] p1_addr;
  logic [3:0]  p1_len;
  logic [63:0] p1_wdata;
  logic [7:0]  p1_wstrb;
  logic        p1_wready, p1_rvalid, p1_gnt, p1_done;
  logic [63:0] p1_rdata;
  logic [31:0] ram_raddr, ram_waddr;
  logic        ram_ren;
  logic [63:0] ram_rdata = '0;
  logic [63:0] ram_wdata;
  logic [7:0]  ram_wen;
  logic        any_out;

  int checks = 0;
  int failures = 0;

  sram_port_arbiter #(.BUS_WIDTH(32), .DATA_WIDTH(64)) dut (
    .aclk(aclk), .areset(areset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_len(p0_len), .p0_wvalid(p0_wvalid),
    .p0_wdata(p0_wdata), .p0_wstrb(p0_wstrb),
    .p0_wready(p0_wready), .p0_rvalid(p0_rvalid),
    .p0_rdata(p0_rdata), .p0_gnt(p0_gnt), .p0_done(p0_done),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_len(p1_len), .p1_wvalid(p1_wvalid),
    .p1_wdata(p1_wdata), .p1_wstrb(p1_wstrb),
    .p1_wready(p1_wready), .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata), .p1_gnt(p1_gnt), .p1_done(p1_done),
    .ram_raddr(ram_raddr), .ram_ren(ram_ren),
    .ram_rdata(ram_rdata), .ram_waddr(ram_waddr),
    .ram_wdata(ram_wdata), .ram_wen(ram_wen)
  );

  always #5 aclk = ~aclk;

  function automatic logic [63:0] mem_f(input logic [31:0] a);
    return {a ^ 32'h5A5A_5A5A, ~a};
  endfunction

  // synchronous SRAM: data appears the cycle after ren
  always @(posedge aclk) begin
    if (ram_ren) ram_rdata <= mem_f(ram_raddr);
  end

  assign any_out = |{p0_wready, p0_rvalid, p0_rdata, p0_gnt,
                     p0_done, p1_wready, p1_rvalid, p1_rdata,
                     p1_gnt, p1_done, ram_raddr, ram_ren,
                     ram_waddr, ram_wdata, ram_wen};

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [7:0]  strb;
    logic [15:0] stall;
    logic [31:0] exp_last;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_len = 0;
    p0_wvalid = 0; p0_wdata = 0; p0_wstrb = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_len = 0;
    p1_wvalid = 0; p1_wdata = 0; p1_wstrb = 0;
  endtask

  task automatic run_burst(input vec_t v, input int id);
    logic [31:0] ea, pa, last_a;
    logic [63:0] wd, g_rdata;
    int beats, rets, cyc;
    bit pend, fin, wv, exp_ren;
    logic g_wready, g_rvalid, g_done, o_any;
    @(negedge aclk);
    if (v.port) begin
      p1_req = 1; p1_we = v.we; p1_addr = v.addr;
      p1_len = v.len; p1_wstrb = v.strb; p1_wvalid = 0;
    end else begin
      p0_req = 1; p0_we = v.we; p0_addr = v.addr;
      p0_len = v.len; p0_wstrb = v.strb; p0_wvalid = 0;
    end
    #1 chk($sformatf("v%0d_idle_gnt", id),
           64'({p1_gnt, p0_gnt}), 64'd0);
    ea = v.addr; pa = 0; last_a = ea;
    beats = 0; rets = 0; cyc = 0; pend = 0; fin = 0;
    while (!fin && cyc < 40) begin
      @(negedge aclk);
      wv = v.we && ((cyc < 16) ? !v.stall[cyc] : 1'b1);
      wd = {32'hC0DE_0000 | 32'(cyc), ea};
      if (v.port) begin
        p1_wvalid = wv; p1_wdata = wd;
      end else begin
        p0_wvalid = wv; p0_wdata = wd;
      end
      #1;
      g_wready = v.port ? p1_wready : p0_wready;
      g_rvalid = v.port ? p1_rvalid : p0_rvalid;
      g_rdata  = v.port ? p1_rdata  : p0_rdata;
      g_done   = v.port ? p1_done   : p0_done;
      o_any = v.port ? (p0_wready | p0_rvalid | p0_done)
                     : (p1_wready | p1_rvalid | p1_done);
      chk($sformatf("v%0d_c%0d_gnt", id, cyc),
          64'({p1_gnt, p0_gnt}), v.port ? 64'd2 : 64'd1);
      chk($sformatf("v%0d_c%0d_other", id, cyc),
          64'(o_any), 64'd0);
      if (!v.we) begin
        exp_ren = (beats <= v.len);
        chk($sformatf("v%0d_c%0d_ren", id, cyc),
            64'(ram_ren), 64'(exp_ren));
        if (exp_ren)
          chk($sformatf("v%0d_c%0d_raddr", id, cyc),
              64'(ram_raddr), 64'(ea));
        chk($sformatf("v%0d_c%0d_rvalid", id, cyc),
            64'(g_rvalid), 64'(pend));
        if (pend) begin
          chk($sformatf("v%0d_c%0d_rdata", id, cyc),
              g_rdata, mem_f(pa));
          rets++;
        end
        fin = pend && (rets == v.len + 1);
        chk($sformatf("v%0d_c%0d_done", id, cyc),
            64'(g_done), 64'(fin));
        pend = exp_ren;
        if (exp_ren) begin
          pa = ea; last_a = ea; ea += 32'd8; beats++;
        end
      end else begin
        chk($sformatf("v%0d_c%0d_wready", id, cyc),
            64'(g_wready), 64'(wv));
        chk($sformatf("v%0d_c%0d_wen", id, cyc),
            64'(ram_wen), wv ? 64'(v.strb) : 64'd0);
        chk($sformatf("v%0d_c%0d_ren", id, cyc),
            64'(ram_ren), 64'd0);
        if (wv) begin
          chk($sformatf("v%0d_c%0d_waddr", id, cyc),
              64'(ram_waddr), 64'(ea));
          chk($sformatf("v%0d_c%0d_wdata", id, cyc),
              ram_wdata, wd);
          last_a = ea; ea += 32'd8; beats++;
        end
        fin = wv && (beats == v.len + 1);
        chk($sformatf("v%0d_c%0d_done", id, cyc),
            64'(g_done), 64'(fin));
      end
      cyc++;
    end
    if (!fin) chk($sformatf("v%0d_timeout", id), 64'd1, 64'd0);
    chk($sformatf("v%0d_cycles", id), 64'(cyc), 64'(v.exp_cyc));
    chk($sformatf("v%0d_last_addr", id),
        64'(last_a), 64'(v.exp_last));
    @(negedge aclk);
    idle_inputs();
    #1 chk($sformatf("v%0d_post_idle", id),
           64'({p1_gnt, p0_gnt}), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge aclk);
    areset = 1;
    idle_inputs();
    @(negedge aclk);
    @(negedge aclk);
    areset = 0;
  endtask

  initial begin : main
    bit winners[4];
    bit exp_win[4];
    int n;
    int budget;

    vecs[0] = '{0, 0, 32'h0000_0100, 4'd3,  8'h00,
                16'h0000, 32'h0000_0118, 5};
    vecs[1] = '{1, 1, 32'h0000_0200, 4'd1,  8'hFF,
                16'h0002, 32'h0000_0208, 3};
    vecs[2] = '{0, 0, 32'hFFFF_FFF8, 4'd1,  8'h00,
                16'h0000, 32'h0000_0000, 3};
    vecs[3] = '{1, 0, 32'h0000_0040, 4'd0,  8'h00,
                16'h0000, 32'h0000_0040, 2};
    vecs[4] = '{0, 1, 32'h0000_1000, 4'd15, 8'h0F,
                16'h0000, 32'h0000_1078, 16};
    vecs[5] = '{0, 1, 32'h0000_0080, 4'd2,  8'hF0,
                16'h0003, 32'h0000_0090, 5};

    areset = 1;
    idle_inputs();
    #12;
    chk("reset_outputs", 64'(any_out), 64'd0);
    @(negedge aclk);
    areset = 0;

    for (int i = 0; i < 6; i++) run_burst(vecs[i], i);

    // simultaneous requests straight out of reset
`ifdef SRAM_ARB_FIXED_PRIO_EN
    exp_win = '{0, 0, 0, 0};
`else
    exp_win = '{0, 1, 0, 1};
`endif
    do_reset();
    p0_req = 1; p0_we = 1; p0_addr = 32'h10; p0_len = 0;
    p0_wvalid = 1; p0_wstrb = 8'hFF;
    p1_req = 1; p1_we = 1; p1_addr = 32'h20; p1_len = 0;
    p1_wvalid = 1; p1_wstrb = 8'hFF;
    n = 0;
    budget = 0;
    while (n < 4 && budget < 40) begin
      @(negedge aclk);
      #1;
      if (p0_done && p1_done)
        chk("tie_double_done", 64'd1, 64'd0);
      if (p0_done || p1_done) begin
        winners[n] = p1_done;
        n++;
      end
      budget++;
    end
    if (n < 4) chk("tie_timeout", 64'(n), 64'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("tie_grant%0d", k),
          64'(winners[k]), 64'(exp_win[k]));
    @(negedge aclk);
    idle_inputs();

    // reset during beat 2 of a len-7 read
    @(negedge aclk);
    p0_req = 1; p0_we = 0; p0_addr = 32'h300; p0_len = 4'd7;
    @(negedge aclk);
    #1 chk("rst_b1_raddr", 64'(ram_raddr), 64'h300);
    @(negedge aclk);
    #1 chk("rst_b2_raddr", 64'(ram_raddr), 64'h308);
    chk("rst_b2_rvalid", 64'(p0_rvalid), 64'd1);
    #1 areset = 1;
    #1 chk("rst_async_outs", 64'(any_out), 64'd0);
    @(negedge aclk);
    #1 chk("rst_hold_outs", 64'(any_out), 64'd0);
    idle_inputs();
    @(negedge aclk);
    areset = 0;
    run_burst('{1, 0, 32'h0000_0500, 4'd0, 8'h00,
                16'h0000, 32'h0000_0500, 2}, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
